// File: rtl/ucode_issue_ctrl_if.sv
// Bundle of the fetch, sequencer and IF/ID signals around the MUL issue controller.
// The slave modport is the controller's view; master is the surrounding pipeline/sequencer view.
interface ucode_issue_ctrl_if;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        if_stall;
    logic        uc_start_mul;
    logic [3:0]  uc_dest_reg;
    logic [3:0]  uc_source_reg;
    logic [15:0] uc_immediate;
    logic [31:0] uc_instr;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        busy;

    modport slave (
        input  if_instr, if_valid, uc_instr,
        output if_stall, uc_start_mul, uc_dest_reg, uc_source_reg, uc_immediate,
               id_instr, id_valid, busy
    );

    modport master (
        output if_instr, if_valid, uc_instr,
        input  if_stall, uc_start_mul, uc_dest_reg, uc_source_reg, uc_immediate,
               id_instr, id_valid, busy
    );
endinterface

// File: rtl/ucode_issue_ctrl.sv
// Detects MUL Rd,Rs,#imm in the fetch stream, stalls IF, starts the microcode sequencer
// and injects its generated instructions into the IF/ID register.
module ucode_issue_ctrl #(
    parameter logic [6:0]  MUL_OPCODE = 7'b0110100,
    parameter logic [31:0] NOP_INSTR  = {5'b11001, 27'b0}
) (
    input logic             clk,
    input logic             rst,
    ucode_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        INJECT,
        HALTWAIT
    } state_t;

    state_t      state;
    logic [16:0] remaining;
    logic [31:0] id_instr_q;
    logic        id_valid_q;
    logic [3:0]  dest_q;
    logic [3:0]  source_q;
    logic [15:0] imm_q;
    logic        is_mul;

    assign is_mul = bus.if_valid && (bus.if_instr[31:25] == MUL_OPCODE);

    assign bus.if_stall      = (state != IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.uc_start_mul  = (state == ISSUE);
    assign bus.uc_dest_reg   = dest_q;
    assign bus.uc_source_reg = source_q;
    assign bus.uc_immediate  = imm_q;
    assign bus.id_instr      = id_instr_q;
    assign bus.id_valid      = id_valid_q;

    // Captured MUL fields are only rewritten in IDLE: the sequencer reads them every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= 17'd0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
            dest_q     <= 4'd0;
            source_q   <= 4'd0;
            imm_q      <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        dest_q     <= bus.if_instr[24:21];
                        source_q   <= bus.if_instr[20:17];
                        imm_q      <= bus.if_instr[15:0];
                        id_instr_q <= NOP_INSTR;
                        id_valid_q <= 1'b0;
                        state      <= ISSUE;
                    end else if (bus.if_valid) begin
                        id_instr_q <= bus.if_instr;
                        id_valid_q <= 1'b1;
                    end else begin
                        id_instr_q <= NOP_INSTR;
                        id_valid_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    id_instr_q <= NOP_INSTR;
                    id_valid_q <= 1'b0;
                    // imm==0 still yields one instruction (SUB Rd,Rd,Rd); 17 bits covers imm=FFFF.
                    remaining  <= (imm_q == 16'd0) ? 17'd1 : ({1'b0, imm_q} + 17'd1);
                    state      <= INJECT;
                end
                INJECT: begin
                    id_instr_q <= bus.uc_instr;
                    id_valid_q <= 1'b1;
                    remaining  <= remaining - 17'd1;
                    if (remaining == 17'd1) begin
                        state <= HALTWAIT;
                    end
                end
                HALTWAIT: begin
                    id_instr_q <= NOP_INSTR;
                    id_valid_q <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    id_instr_q <= NOP_INSTR;
                    id_valid_q <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
